// File: rtl/periph_bus_bridge_if.sv
// Core data-memory port bundle: req/gnt/rvalid handshake, word address
// plus byte enables.
//   master : core side (drives request fields, receives gnt/response)
//   slave  : bridge side (drives gnt/response, receives request fields)
interface periph_bus_bridge_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/periph_bus_bridge.sv
// Core data port -> memory-mapped peripheral bridge.
// Decodes the peripheral window, one-hot selects a slot, turns lane byte
// enables into byte-offset addressing (write data shifted down to bit 0,
// read data shifted back up to its lanes), inserts WAIT_CYCLES wait states
// and returns a single-cycle response (err for illegal accesses).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   bus           : core handshake (slave modport)
//   sel_o         : one-hot slot select, only during ACCESS
//   write_o       : single write strobe in the last ACCESS cycle
//   addr_o/be_o/wdata_o : byte offset, shifted enables/data (held when idle)
//   rdata_i       : per-slot read data, slot k at [32k+31:32k]
module periph_bus_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned SLV_AW      = 5,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  periph_bus_bridge_if.slave      bus,
  output logic [NUM_SLV-1:0]      sel_o,
  output logic                    write_o,
  output logic [SLV_AW-1:0]       addr_o,
  output logic [3:0]              be_o,
  output logic [31:0]             wdata_o,
  input  logic [32*NUM_SLV-1:0]   rdata_i
);
  localparam int unsigned HI = SLV_AW + SEL_W;

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [1:0]          off_q;
  logic [3:0]          lane_be_q;
  logic [NUM_SLV-1:0]  sel_q;
  logic [SLV_AW-1:0]   addr_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;

  // ---------------- request decode ----------------
  logic                be_ok, hit, slot_ok, legal, last, hs;
  logic [1:0]          off_d;
  logic [SEL_W-1:0]    slot_d;
  logic [NUM_SLV-1:0]  sel_d;
  logic [SLV_AW-1:0]   addr_d;
  logic [3:0]          be_d;
  logic [31:0]         wdata_d;

  always_comb begin
    be_ok = 1'b1;
    off_d = 2'd0;
    case (bus.data_be)
      4'b0001, 4'b0011, 4'b1111: off_d = 2'd0;
      4'b0010:                   off_d = 2'd1;
      4'b0100, 4'b1100:          off_d = 2'd2;
      4'b1000:                   off_d = 2'd3;
      default:                   be_ok = 1'b0;
    endcase
  end

  assign slot_d  = bus.data_addr[HI-1:SLV_AW];
  assign hit     = (bus.data_addr[31:HI] == BASE_ADDR[31:HI]);
  assign slot_ok = (32'(slot_d) < NUM_SLV);
  assign legal   = hit & slot_ok & be_ok;
  assign addr_d  = {bus.data_addr[SLV_AW-1:2], off_d};
  assign be_d    = bus.data_be >> off_d;
  assign wdata_d = bus.data_wdata >> {off_d, 3'b000};

  // Loop compare keeps the one-hot in range when NUM_SLV < 2^SEL_W.
  always_comb begin
    sel_d = '0;
    for (int k = 0; k < int'(NUM_SLV); k++) sel_d[k] = (32'(slot_d) == 32'(k));
  end

  // ---------------- handshake ----------------
  assign last         = (state_q == ACCESS) && (cnt_q == 4'd0);
  // Accept in IDLE, ERROR, or the final ACCESS cycle (back-to-back).
  assign bus.data_gnt = bus.data_req & ((state_q != ACCESS) | last);
  assign hs           = bus.data_gnt;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      off_q     <= 2'd0;
      lane_be_q <= 4'd0;
      sel_q     <= '0;
      addr_q    <= '0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
    end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end else if (hs) begin
      we_q <= bus.data_we;
      if (legal) begin
        state_q   <= ACCESS;
        cnt_q     <= 4'(WAIT_CYCLES);
        sel_q     <= sel_d;
        addr_q    <= addr_d;
        be_q      <= be_d;
        wdata_q   <= wdata_d;
        off_q     <= off_d;
        lane_be_q <= bus.data_be;
      end else begin
        // Illegal: slave-side bus fields keep their old values, no select.
        state_q <= ERROR;
        sel_q   <= '0;
      end
    end else begin
      state_q <= IDLE;
      sel_q   <= '0;
    end
  end

  // ---------------- outputs ----------------
  // Strobe/response decode straight from state so an async reset drops
  // them immediately.
  assign sel_o           = sel_q;
  assign addr_o          = addr_q;
  assign be_o            = be_q;
  assign wdata_o         = wdata_q;
  assign write_o         = last & we_q;
  assign bus.data_rvalid = last | (state_q == ERROR);
  assign bus.data_err    = (state_q == ERROR);

  // Slave rdata is combinational from addr_o, so the read return path is
  // combinational too (needed for zero-wait-state reads).
  logic [31:0] rsel, lane_mask;
  always_comb begin
    rsel = 32'd0;
    for (int k = 0; k < int'(NUM_SLV); k++)
      if (sel_q[k]) rsel = rsel | rdata_i[32*k +: 32];
  end
  assign lane_mask = {{8{lane_be_q[3]}}, {8{lane_be_q[2]}},
                      {8{lane_be_q[1]}}, {8{lane_be_q[0]}}};
  assign bus.data_rdata = (last && !we_q) ?
                          ((rsel << {off_q, 3'b000}) & lane_mask) : 32'd0;
endmodule

// File: tb/tb_periph_bus_bridge.sv
module tb_periph_bus_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // DUT0: WAIT=0, 4 slots
  periph_bus_bridge_if b0();
  logic [3:0]   sel0, be0;
  logic         w0;
  logic [4:0]   a0;
  logic [31:0]  wd0;
  logic [127:0] rd0;
  assign rd0 = {32'h8765_4321, 32'hCAFE_F00D, 32'h0000_00AB, 32'hFFFF_BEEF};
  periph_bus_bridge #(.NUM_SLV(4), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b0), .sel_o(sel0), .write_o(w0),
    .addr_o(a0), .be_o(be0), .wdata_o(wd0), .rdata_i(rd0));

  // DUT1: WAIT=2, 3 slots
  periph_bus_bridge_if b1();
  logic [2:0]   sel1;
  logic [3:0]   be1;
  logic         w1;
  logic [4:0]   a1;
  logic [31:0]  wd1;
  logic [95:0]  rd1;
  assign rd1 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  periph_bus_bridge #(.NUM_SLV(3), .WAIT_CYCLES(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b1), .sel_o(sel1), .write_o(w1),
    .addr_o(a1), .be_o(be1), .wdata_o(wd1), .rdata_i(rd1));

  // DUT2: WAIT=3, 4 slots
  periph_bus_bridge_if b2();
  logic [3:0]   sel2, be2;
  logic         w2;
  logic [4:0]   a2;
  logic [31:0]  wd2;
  logic [127:0] rd2;
  assign rd2 = {32'h4444_4444, 32'h3333_3333, 32'h1357_2468, 32'h0000_0000};
  periph_bus_bridge #(.NUM_SLV(4), .WAIT_CYCLES(3)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b2), .sel_o(sel2), .write_o(w2),
    .addr_o(a2), .be_o(be2), .wdata_o(wd2), .rdata_i(rd2));

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  sel;
    logic [4:0]  ao;
    logic [3:0]  beo;
    logic [31:0] wo;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wk, lat, rv_seen;
    logic hs1;
    logic [15:0] gnt_m, wr_m;

    //         we  be       addr          wdata         err sel      ao     beo      wo            rd
    vecs[0]  = '{1, 4'b1111, 32'h2000_0004, 32'h1234_5678, 0, 4'b0001, 5'h04, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[1]  = '{0, 4'b0010, 32'h2000_0020, 32'hAABB_CCDD, 0, 4'b0010, 5'h01, 4'b0001, 32'h00AA_BBCC, 32'h0000_AB00};
    vecs[2]  = '{0, 4'b1100, 32'h2000_0018, 32'h0,         0, 4'b0001, 5'h1A, 4'b0011, 32'h0,         32'hBEEF_0000};
    vecs[3]  = '{0, 4'b1000, 32'h2000_0048, 32'h0,         0, 4'b0100, 5'h0B, 4'b0001, 32'h0,         32'h0D00_0000};
    vecs[4]  = '{1, 4'b0011, 32'h2000_007C, 32'hDEAD_BEEF, 0, 4'b1000, 5'h1C, 4'b0011, 32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{1, 4'b1100, 32'h2000_0064, 32'h1122_3344, 0, 4'b1000, 5'h06, 4'b0011, 32'h0000_1122, 32'h0};
    vecs[6]  = '{0, 4'b0001, 32'h2000_0000, 32'h0,         0, 4'b0001, 5'h00, 4'b0001, 32'h0,         32'h0000_00EF};
    // illegal: slave-side fields hold the previous (vecs[6]) values
    vecs[7]  = '{1, 4'b0110, 32'h2000_0000, 32'hFFFF_FFFF, 1, 4'b0000, 5'h00, 4'b0001, 32'h0,         32'h0};
    vecs[8]  = '{1, 4'b1111, 32'h3000_0000, 32'hFFFF_FFFF, 1, 4'b0000, 5'h00, 4'b0001, 32'h0,         32'h0};
    vecs[9]  = '{0, 4'b0000, 32'h2000_0004, 32'h0,         1, 4'b0000, 5'h00, 4'b0001, 32'h0,         32'h0};
    vecs[10] = '{0, 4'b1111, 32'h2000_0080, 32'h0,         1, 4'b0000, 5'h00, 4'b0001, 32'h0,         32'h0};

    b0.data_req = 0; b0.data_we = 0; b0.data_be = 0; b0.data_addr = 0; b0.data_wdata = 0;
    b1.data_req = 0; b1.data_we = 0; b1.data_be = 0; b1.data_addr = 0; b1.data_wdata = 0;
    b2.data_req = 0; b2.data_we = 0; b2.data_be = 0; b2.data_addr = 0; b2.data_wdata = 0;

    // ---- reset state ----
    #3;
    chk("rst_rvalid", 32'(b0.data_rvalid), 32'd0);
    chk("rst_err",    32'(b0.data_err),    32'd0);
    chk("rst_sel",    32'(sel0),           32'd0);
    chk("rst_write",  32'(w0),             32'd0);
    chk("rst_addr",   32'(a0),             32'd0);
    chk("rst_be",     32'(be0),            32'd0);
    chk("rst_wdata",  wd0,                 32'd0);
    chk("rst_rdata",  b0.data_rdata,       32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ---- table vectors, WAIT=0 ----
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_idle_rvalid", i), 32'(b0.data_rvalid), 32'd0);
      chk($sformatf("v%0d_idle_sel", i),    32'(sel0),           32'd0);
      b0.data_req = 1; b0.data_we = vecs[i].we; b0.data_be = vecs[i].be;
      b0.data_addr = vecs[i].addr; b0.data_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(b0.data_gnt), 32'd1);
      @(posedge clk); #1;
      b0.data_req = 0;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), 32'(b0.data_rvalid), 32'd1);
      chk($sformatf("v%0d_err", i),    32'(b0.data_err),    32'(vecs[i].err));
      chk($sformatf("v%0d_sel", i),    32'(sel0),           32'(vecs[i].sel));
      chk($sformatf("v%0d_write", i),  32'(w0),             32'(vecs[i].we & ~vecs[i].err));
      chk($sformatf("v%0d_addr", i),   32'(a0),             32'(vecs[i].ao));
      chk($sformatf("v%0d_be", i),     32'(be0),            32'(vecs[i].beo));
      chk($sformatf("v%0d_wdata", i),  wd0,                 vecs[i].wo);
      chk($sformatf("v%0d_rdata", i),  b0.data_rdata,       vecs[i].rd);
    end

    // ---- back-to-back at WAIT=0: read slot2 then write slot1 ----
    @(negedge clk);
    b0.data_req = 1; b0.data_we = 0; b0.data_be = 4'b1111;
    b0.data_addr = 32'h2000_0040; b0.data_wdata = 32'h0;
    #1 chk("b2b_gnt0", 32'(b0.data_gnt), 32'd1);
    @(posedge clk); #1;
    b0.data_we = 1; b0.data_be = 4'b0100;
    b0.data_addr = 32'h2000_0028; b0.data_wdata = 32'h0055_0000;
    @(negedge clk);
    chk("b2b_gnt1",   32'(b0.data_gnt),    32'd1);
    chk("b2b_rv0",    32'(b0.data_rvalid), 32'd1);
    chk("b2b_rdata0", b0.data_rdata,       32'hCAFE_F00D);
    chk("b2b_sel0",   32'(sel0),           32'b0100);
    chk("b2b_wr0",    32'(w0),             32'd0);
    @(posedge clk); #1;
    b0.data_req = 0;
    @(negedge clk);
    chk("b2b_rv1",    32'(b0.data_rvalid), 32'd1);
    chk("b2b_wr1",    32'(w0),             32'd1);
    chk("b2b_sel1",   32'(sel0),           32'b0010);
    chk("b2b_addr1",  32'(a0),             32'h0A);
    chk("b2b_be1",    32'(be0),            32'b0001);
    chk("b2b_wdata1", wd0,                 32'h0000_0055);
    @(negedge clk);
    chk("b2b_done", 32'(b0.data_rvalid), 32'd0);

    // ---- WAIT=2, NUM_SLV=3: slot 3 illegal, error is immediate ----
    @(negedge clk);
    b1.data_req = 1; b1.data_we = 1; b1.data_be = 4'b1111;
    b1.data_addr = 32'h2000_0060; b1.data_wdata = 32'hFFFF_FFFF;
    #1 chk("slot3_gnt", 32'(b1.data_gnt), 32'd1);
    @(posedge clk); #1;
    b1.data_req = 0;
    @(negedge clk);
    chk("slot3_rvalid", 32'(b1.data_rvalid), 32'd1);
    chk("slot3_err",    32'(b1.data_err),    32'd1);
    chk("slot3_rdata",  b1.data_rdata,       32'd0);
    chk("slot3_sel",    32'(sel1),           32'd0);
    chk("slot3_write",  32'(w1),             32'd0);
    @(negedge clk);
    chk("slot3_after", 32'(b1.data_rvalid), 32'd0);

    // ---- WAIT=2: four back-to-back writes ----
    gnt_m = 16'h0249;  // cycles 0,3,6,9
    wr_m  = 16'h1248;  // cycles 3,6,9,12
    n = 0; wk = 0;
    @(posedge clk); #1;
    b1.data_req = 1; b1.data_we = 1; b1.data_be = 4'b1111;
    b1.data_addr = 32'h2000_0000; b1.data_wdata = 32'hA0A0_0000;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk($sformatf("bb_c%0d_gnt", c),    32'(b1.data_gnt),    32'(gnt_m[c]));
      chk($sformatf("bb_c%0d_write", c),  32'(w1),             32'(wr_m[c]));
      chk($sformatf("bb_c%0d_rvalid", c), 32'(b1.data_rvalid), 32'(wr_m[c]));
      if (w1) begin
        chk($sformatf("bb_w%0d_wdata", wk), wd1, 32'hA0A0_0000 | 32'(wk));
        chk($sformatf("bb_w%0d_sel", wk), 32'(sel1), 32'(3'b001 << (wk % 3)));
        wk++;
      end
      hs1 = b1.data_req & b1.data_gnt;
      @(posedge clk); #1;
      if (hs1) begin
        n++;
        if (n < 4) begin
          b1.data_addr  = 32'h2000_0000 + 32'((n % 3) * 32) + 32'(4 * n);
          b1.data_wdata = 32'hA0A0_0000 | 32'(n);
        end else begin
          b1.data_req = 0;
        end
      end
    end
    chk("bb_strobes", 32'(wk), 32'd4);

    // ---- WAIT=3: reset in the write cycle ----
    @(negedge clk);
    b2.data_req = 1; b2.data_we = 1; b2.data_be = 4'b1111;
    b2.data_addr = 32'h2000_0000; b2.data_wdata = 32'h0BAD_F00D;
    #1 chk("rm_gnt", 32'(b2.data_gnt), 32'd1);
    @(posedge clk); #1;
    b2.data_req = 0;
    @(negedge clk);
    chk("rm_c1_write", 32'(w2),   32'd0);
    chk("rm_c1_sel",   32'(sel2), 32'b0001);
    repeat (3) @(posedge clk);
    #1;
    chk("rm_c4_write",  32'(w2),             32'd1);
    chk("rm_c4_rvalid", 32'(b2.data_rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_rst_write",  32'(w2),             32'd0);
    chk("rm_rst_sel",    32'(sel2),           32'd0);
    chk("rm_rst_rvalid", 32'(b2.data_rvalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b2.data_rvalid) rv_seen++;
    end
    chk("rm_no_resp", 32'(rv_seen), 32'd0);

    @(negedge clk);
    b2.data_req = 1; b2.data_we = 0; b2.data_be = 4'b1111;
    b2.data_addr = 32'h2000_0020; b2.data_wdata = 32'h0;
    #1 chk("rm2_gnt", 32'(b2.data_gnt), 32'd1);
    @(posedge clk); #1;
    b2.data_req = 0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (b2.data_rvalid) begin
        lat = i;
        break;
      end
    end
    chk("rm2_latency", 32'(lat),           32'd4);
    chk("rm2_rdata",   b2.data_rdata,      32'h1357_2468);
    chk("rm2_err",     32'(b2.data_err),   32'd0);
    chk("rm2_sel",     32'(sel2),          32'b0010);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/periph_bus_bridge.md
Name: periph_bus_bridge

Overview:
- Sits between the core's data-memory port (req/gnt/rvalid handshake, word address plus byte enables) and the memory-mapped peripherals, such as the timer.
- Decodes the peripheral window and one-hot selects a slave.
- Converts lane-aligned byte enables into the byte-offset register addressing the peripherals use. Writes are shifted down to bit 0 and read data is shifted back up to the active lanes.
- Sequences each access with configurable wait states and returns a one-cycle response, with an error for illegal accesses.

Parameters:
- BASE_ADDR, 32'h2000_0000, byte base of the peripheral window; aligned to 2^(SLV_AW+SEL_W).
- NUM_SLV, 4, number of peripheral slots; must be ≤ 2^SEL_W.
- SEL_W, 2, address bits used for slot index.
- SLV_AW, 5, byte-address width per slot (32-byte slot).
- WAIT_CYCLES, 0, extra ACCESS cycles before the response (0..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i  in  1  core request
- data_gnt_o  out  1  request accepted this cycle
- data_we_i  in  1  1=write
- data_be_i  in  4  lane byte enables
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_wdata_i  in  32  lane-aligned write data
- data_rvalid_o  out  1  response valid (one cycle per granted request)
- data_rdata_o  out  32  lane-aligned read data
- data_err_o  out  1  error response, qualified by rvalid
- sel_o  out  NUM_SLV  one-hot slave select
- write_o  out  1  write strobe to selected slave
- addr_o  out  SLV_AW  byte offset within slot
- be_o  out  4  byte enables shifted down to bit 0
- wdata_o  out  32  write data shifted down to bit 0
- rdata_i  in  32*NUM_SLV  slave read data, slot k at [32k+31:32k], combinational from addr_o

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous active-low; all state clears while rst_ni=0.
- Reset values: state=IDLE; gnt, rvalid, err, write_o, sel_o, be_o all 0; addr_o, wdata_o, rdata_o all 0; wait counter 0.
- States:
  - IDLE: no access in progress.
  - ACCESS: registered request driven to the slave; wait counter counts down from WAIT_CYCLES.
  - ERROR: one-cycle error response.
- Grant rule: data_gnt_o = data_req_i & (state==IDLE | last ACCESS cycle | ERROR). A handshake occurs on the rising edge where req&gnt=1.
- On handshake the request is registered; the next state is ACCESS (legal) or ERROR (illegal).
- Legal be values and offset o: 0001→0, 0010→1, 0100→2, 1000→3, 0011→0, 1100→2, 1111→0. All other be values (including 0000) are illegal.
- Decode:
  - Hit requires addr[31:SLV_AW+SEL_W] == BASE_ADDR[31:SLV_AW+SEL_W].
  - Slot index k = addr[SLV_AW+SEL_W-1:SLV_AW]; k ≥ NUM_SLV is illegal.
  - addr_o = {addr[SLV_AW-1:2], o[1:0]}.
  - be_o = be >> o.
  - wdata_o = wdata >> 8*o.
- Illegal request (miss, bad slot, bad be): no slave signal toggles (sel_o=0, write_o=0).
  - ERROR state gives rvalid=1, err=1, rdata=0 in the cycle after the handshake, regardless of WAIT_CYCLES.
- ACCESS timing:
  - Lasts WAIT_CYCLES+1 cycles.
  - sel_o, addr_o, be_o and wdata_o are held stable throughout.
  - write_o=1 only in the last ACCESS cycle, and only for writes. This gives exactly one strobe per write, which is required for side-effect registers.
  - The last ACCESS cycle drives rvalid=1, err=0.
  - data_rdata_o = (rdata_i[slot k] << 8*o) masked to lanes in the registered be; for writes, rdata=0.
- Response latency: WAIT_CYCLES+1 cycles from handshake. A new handshake in the last ACCESS cycle goes straight into the next ACCESS or ERROR, so throughput is 1/(WAIT_CYCLES+1) and 1 access/cycle at WAIT_CYCLES=0.
- Idle outputs: outside ACCESS, sel_o=0, write_o=0, rvalid=0. addr_o, be_o and wdata_o hold their last values.
- Ordering: responses are strictly in order; there is at most one outstanding access.
- Reset mid-access: the access is abandoned and no response is issued. If reset falls during the write cycle, write_o deasserts immediately.
- Requests without gnt: data_req_i held high with changing fields while not granted has no effect until the handshake.

Test Plan:
- WAIT_CYCLES=0; write be=1111, addr=0x2000_0004, wdata=0x1234_5678 → next cycle sel_o=0001, addr_o=0x04, write_o=1, wdata_o=0x1234_5678, rvalid=1, err=0.
- Read be=0010 at 0x2000_0020, slot1 rdata_i=0x0000_00AB → addr_o=0x01, be_o=0001, data_rdata_o=0x0000_AB00.
- Read be=1100 at 0x2000_0018, slot0 rdata_i=0xFFFF_BEEF → addr_o=0x1A, data_rdata_o=0xBEEF_0000.
- Illegal cases, each → err=1, rdata=0, sel_o and write_o never asserted:
  - be=0110;
  - addr=0x3000_0000;
  - NUM_SLV=3 with slot 3.
- WAIT_CYCLES=2; four back-to-back writes → gnt on cycles 0,3,6,9; write_o high exactly once per access (cycles 3,6,9,12); rvalid one cycle each.
- Reset asserted during ACCESS with WAIT_CYCLES=3 → write_o, sel_o and rvalid go to 0 asynchronously; no response after release; the next request completes normally.
